// File: rtl/fifo_write_ctrl_pkg.sv
// Shared FIFO definitions: FSM state encodings and depth helper.
package fifo_write_ctrl_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_t;

    function automatic int fifo_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage

// File: rtl/fifo_wrap_counter.sv
// n-bit wrapping up-counter with async active-low reset; used for FIFO addresses.
module fifo_wrap_counter #(
    parameter int n = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [n-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (inc) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_write_ctrl.sv
// FIFO write-side controller: write address, occupancy count and EMPTY/PARTIAL/FULL flags.
// Optional sticky overflow/underflow outputs when FIFO_ERR_FLAGS_EN is defined.
module fifo_write_ctrl
    import fifo_write_ctrl_pkg::*;
#(
    parameter int n        = 3,
    parameter int AF_LEVEL = 2**n - 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         write,
    input  logic         read,
    output logic [n-1:0] write_addr,
    output logic         wr_en,
    output logic [n:0]   count,
    output logic         fifo_empty,
    output logic         fifo_full,
    output logic         almost_full
`ifdef FIFO_ERR_FLAGS_EN
   ,output logic         overflow,
    output logic         underflow
`endif
);

    localparam int DEPTH = fifo_depth(n);
    localparam int CW    = n + 1;

    fifo_state_t   state;
    fifo_state_t   next_state;
    logic [CW-1:0] next_count;
    logic          wr_ok;
    logic          rd_ok;

    assign wr_ok = write & ~fifo_full;
    assign rd_ok = read & ~fifo_empty;
    assign wr_en = wr_ok;

    fifo_wrap_counter #(.n(n)) u_addr_cnt (
        .clk (clk),
        .rst (rst),
        .inc (wr_ok),
        .q   (write_addr)
    );

    always_comb begin
        next_state = state;
        next_count = count;
        if (wr_ok && !rd_ok) begin
            next_count = count + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            next_count = count - CW'(1);
        end
        case (state)
            EMPTY: begin
                if (wr_ok) next_state = (DEPTH == 1) ? FULL : PARTIAL;
            end
            PARTIAL: begin
                if (wr_ok && !rd_ok && count == CW'(DEPTH - 1)) begin
                    next_state = FULL;
                end else if (rd_ok && !wr_ok && count == CW'(1)) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (rd_ok) next_state = (DEPTH == 1) ? EMPTY : PARTIAL;
            end
            // An unreachable code falls back to a cleanly empty FIFO.
            default: begin
                next_state = EMPTY;
                next_count = '0;
            end
        endcase
    end

    // Flags are registered from the next state/count so they track count exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            count       <= '0;
            fifo_empty  <= 1'b1;
            fifo_full   <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            state       <= next_state;
            count       <= next_count;
            fifo_empty  <= (next_state == EMPTY);
            fifo_full   <= (next_state == FULL);
            almost_full <= (next_count >= CW'(AF_LEVEL));
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write && fifo_full)  overflow  <= 1'b1;
            if (read && fifo_empty)  underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed, scoreboard-based bench for fifo_write_ctrl (n=3, AF_LEVEL=6).
module tb_fifo_write_ctrl;

    localparam int N     = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic         clk;
    logic         rst;
    logic         write;
    logic         read;
    logic [N-1:0] write_addr;
    logic         wr_en;
    logic [N:0]   count;
    logic         fifo_empty;
    logic         fifo_full;
    logic         almost_full;
`ifdef FIFO_ERR_FLAGS_EN
    logic         overflow;
    logic         underflow;
`endif

    typedef struct {
        int addr;
        int cnt;
        int empty;
        int full;
        int af;
        int ovf;
        int unf;
    } exp_t;

    exp_t sb[$];

    int m_addr;
    int m_count;
    int m_ovf;
    int m_unf;
    int check_count;
    int pass_count;
    int fail_count;

    fifo_write_ctrl #(.n(N), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .rst         (rst),
        .write       (write),
        .read        (read),
        .write_addr  (write_addr),
        .wr_en       (wr_en),
        .count       (count),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .almost_full (almost_full)
`ifdef FIFO_ERR_FLAGS_EN
       ,.overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_addr  = 0;
        m_count = 0;
        m_ovf   = 0;
        m_unf   = 0;
        sb.delete();
    endtask

    task automatic checkReset(input string tag, input int exp_wr_en);
        checkValue({tag, ".addr"},  32'(write_addr), 0);
        checkValue({tag, ".count"}, 32'(count), 0);
        checkValue({tag, ".empty"}, 32'(fifo_empty), 1);
        checkValue({tag, ".full"},  32'(fifo_full), 0);
        checkValue({tag, ".af"},    32'(almost_full), 0);
        checkValue({tag, ".wr_en"}, 32'(wr_en), 32'(exp_wr_en));
`ifdef FIFO_ERR_FLAGS_EN
        checkValue({tag, ".ovf"},   32'(overflow), 0);
        checkValue({tag, ".unf"},   32'(underflow), 0);
`endif
    endtask

    // Drive one cycle of requests from a negedge; the model predicts the post-edge state.
    task automatic applyStimulus(input string tag, input int w, input int r);
        int   wr_ok;
        int   rd_ok;
        exp_t e;
        write = w[0];
        read  = r[0];
        #1;
        wr_ok = (w != 0 && m_count != DEPTH) ? 1 : 0;
        rd_ok = (r != 0 && m_count != 0) ? 1 : 0;
        checkValue({tag, ".wr_en"}, 32'(wr_en), 32'(wr_ok));
        if (w != 0 && m_count == DEPTH) m_ovf = 1;
        if (r != 0 && m_count == 0)     m_unf = 1;
        if (wr_ok != 0) m_addr = (m_addr + 1) % DEPTH;
        m_count = m_count + wr_ok - rd_ok;
        e.addr  = m_addr;
        e.cnt   = m_count;
        e.empty = (m_count == 0) ? 1 : 0;
        e.full  = (m_count == DEPTH) ? 1 : 0;
        e.af    = (m_count >= AF) ? 1 : 0;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checkValue({tag, ".sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            checkValue({tag, ".addr"},  32'(write_addr), 32'(e.addr));
            checkValue({tag, ".count"}, 32'(count), 32'(e.cnt));
            checkValue({tag, ".empty"}, 32'(fifo_empty), 32'(e.empty));
            checkValue({tag, ".full"},  32'(fifo_full), 32'(e.full));
            checkValue({tag, ".af"},    32'(almost_full), 32'(e.af));
`ifdef FIFO_ERR_FLAGS_EN
            checkValue({tag, ".ovf"},   32'(overflow), 32'(e.ovf));
            checkValue({tag, ".unf"},   32'(underflow), 32'(e.unf));
`endif
        end
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        fail_count  = 0;
        write = 1'b0;
        read  = 1'b0;
        rst   = 1'b0;
        modelReset();

        repeat (2) @(negedge clk);
        checkReset("reset", 0);
        rst = 1'b1;

        // 1: fill with 8 back-to-back writes
        for (int i = 0; i < DEPTH; i++) begin
            checkValue("fill.addr_before", 32'(write_addr), 32'(i));
            applyStimulus("fill", 1, 0);
            checkOutput("fill");
        end

        // 2: write while full is dropped
        applyStimulus("ovf", 1, 0);
        checkOutput("ovf");

        // 3: read+write from full acts as read only
        applyStimulus("full_rw", 1, 1);
        checkOutput("full_rw");

        // drain to empty
        for (int i = 0; i < DEPTH - 1; i++) begin
            applyStimulus("drain", 0, 1);
            checkOutput("drain");
        end

        // 4: read+write from empty acts as write only
        applyStimulus("empty_rw", 1, 1);
        checkOutput("empty_rw");

        // 5: fill to 3, then read for 4 cycles
        for (int i = 0; i < 2; i++) begin
            applyStimulus("fill3", 1, 0);
            checkOutput("fill3");
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus("rd4", 0, 1);
            checkOutput("rd4");
        end

        // PARTIAL read+write holds count while address advances
        applyStimulus("part_w", 1, 0);
        checkOutput("part_w");
        applyStimulus("part_rw", 1, 1);
        checkOutput("part_rw");

        // 6: interleaved writes/reads, then async reset mid-cycle
        for (int i = 0; i < 10; i++) begin
            applyStimulus("mix", 1, (i % 3 == 1) ? 1 : 0);
            checkOutput("mix");
        end
        write = 1'b1;
        read  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkReset("async_rst", 1);
        @(posedge clk);
        @(negedge clk);
        checkReset("rst_hold", 1);
        write = 1'b0;
        rst   = 1'b1;
        #1;
        applyStimulus("post_rst", 1, 0);
        checkOutput("post_rst");

        checkValue("sb_drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
